// File: rtl/sa_control_if.sv
// Instruction and array/memory control bundle for sa_control.
// The controller side is the slave modport; the instruction source is the master.
interface sa_control_if #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4
);
    localparam int IDX_W   = $clog2(N);
    localparam int INSTR_W = 3 + 2 * IDX_W + DATA_WIDTH;

    // instruction is qualified by instr_valid; there is no backpressure, so
    // every rising edge with instr_valid=1 accepts the word.
    logic                    instr_valid;
    logic [INSTR_W-1:0]      instruction;

    logic                    busy;
    logic                    done;

    logic                    array_write_enable;
    logic [IDX_W-1:0]        array_output_row;
    logic [IDX_W-1:0]        array_output_col;
    logic                    result_valid;

    logic [DATA_WIDTH-1:0]   mema_data_in;
    logic                    mema_write_enable;
    logic [IDX_W-1:0]        mema_write_line;
    logic [IDX_W-1:0]        mema_write_elem;
    logic [N-1:0]            mema_read_enable;
    logic [N*IDX_W-1:0]      mema_read_elem;

    logic [DATA_WIDTH-1:0]   memb_data_in;
    logic                    memb_write_enable;
    logic [IDX_W-1:0]        memb_write_line;
    logic [IDX_W-1:0]        memb_write_elem;
    logic [N-1:0]            memb_read_enable;
    logic [N*IDX_W-1:0]      memb_read_elem;

    modport master (
        output instr_valid, instruction,
        input  busy, done,
        input  array_write_enable, array_output_row, array_output_col, result_valid,
        input  mema_data_in, mema_write_enable, mema_write_line, mema_write_elem,
        input  mema_read_enable, mema_read_elem,
        input  memb_data_in, memb_write_enable, memb_write_line, memb_write_elem,
        input  memb_read_enable, memb_read_elem
    );

    modport slave (
        input  instr_valid, instruction,
        output busy, done,
        output array_write_enable, array_output_row, array_output_col, result_valid,
        output mema_data_in, mema_write_enable, mema_write_line, mema_write_elem,
        output mema_read_enable, mema_read_elem,
        output memb_data_in, memb_write_enable, memb_write_line, memb_write_elem,
        output memb_read_enable, memb_read_elem
    );
endinterface

// File: rtl/sa_control.sv
// Systolic array sequencer: decodes START/STOP/LOAD/STORE and skews the A/B feed.
// Optional sticky err output for rejected commands is enabled by SA_CTRL_ERR_EN.
module sa_control #(
    parameter int DATA_WIDTH = 8,
    parameter int N          = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef SA_CTRL_ERR_EN
    output logic        err,
`endif
    sa_control_if.slave bus
);
    localparam int IDX_W   = $clog2(N);
    localparam int INSTR_W = 3 + 2 * IDX_W + DATA_WIDTH;
    localparam int CNT_W   = $clog2(2 * N + 2);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * N + 1);

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b10;
    localparam logic [1:0] OP_STORE = 2'b11;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [1:0]            f_opcode;
    logic                  f_mem_sel;
    logic [IDX_W-1:0]      f_row;
    logic [IDX_W-1:0]      f_col;
    logic [DATA_WIDTH-1:0] f_data;

    assign f_opcode  = bus.instruction[INSTR_W-1 -: 2];
    assign f_mem_sel = bus.instruction[INSTR_W-3];
    assign f_row     = bus.instruction[DATA_WIDTH+IDX_W +: IDX_W];
    assign f_col     = bus.instruction[DATA_WIDTH +: IDX_W];
    assign f_data    = bus.instruction[DATA_WIDTH-1:0];

    logic acc_start;
    logic acc_stop;
    logic acc_load;
    logic acc_store;

    assign acc_start = bus.instr_valid && (f_opcode == OP_START);
    assign acc_stop  = bus.instr_valid && (f_opcode == OP_STOP);
    assign acc_load  = bus.instr_valid && (f_opcode == OP_LOAD);
    assign acc_store = bus.instr_valid && (f_opcode == OP_STORE);

    logic [0:0]            state_q,    state_d;
    logic [CNT_W-1:0]      cnt_q,      cnt_d;
    logic                  done_q,     done_d;
    logic                  we_a_q,     we_a_d;
    logic                  we_b_q,     we_b_d;
    logic [DATA_WIDTH-1:0] ld_data_q,  ld_data_d;
    logic [IDX_W-1:0]      ld_line_q,  ld_line_d;
    logic [IDX_W-1:0]      ld_elem_q,  ld_elem_d;
    logic                  rv_q,       rv_d;
    logic [IDX_W-1:0]      out_row_q,  out_row_d;
    logic [IDX_W-1:0]      out_col_q,  out_col_d;

    logic running;
    assign running = (state_q == ST_RUN);

    // Run sequencer: cnt walks 0..2N+1 while running; only natural completion pulses done.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (acc_start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (acc_stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // LOAD works in either state; the captured word feeds both memory ports.
    always_comb begin
        we_a_d    = acc_load && !f_mem_sel;
        we_b_d    = acc_load && f_mem_sel;
        ld_data_d = ld_data_q;
        ld_line_d = ld_line_q;
        ld_elem_d = ld_elem_q;
        if (acc_load) begin
            ld_data_d = f_data;
            ld_line_d = f_row;
            ld_elem_d = f_col;
        end
    end

    always_comb begin
        rv_d      = 1'b0;
        out_row_d = out_row_q;
        out_col_d = out_col_q;
        if (acc_store && !running) begin
            rv_d      = 1'b1;
            out_row_d = f_row;
            out_col_d = f_col;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            we_a_q    <= 1'b0;
            we_b_q    <= 1'b0;
            ld_data_q <= '0;
            ld_line_q <= '0;
            ld_elem_q <= '0;
            rv_q      <= 1'b0;
            out_row_q <= '0;
            out_col_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            we_a_q    <= we_a_d;
            we_b_q    <= we_b_d;
            ld_data_q <= ld_data_d;
            ld_line_q <= ld_line_d;
            ld_elem_q <= ld_elem_d;
            rv_q      <= rv_d;
            out_row_q <= out_row_d;
            out_col_q <= out_col_d;
        end
    end

`ifdef SA_CTRL_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((acc_start || acc_store) && running) begin
            err_d = 1'b1;
        end else if (acc_stop && !running) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign err = err_q;
`endif

    // Lane i is fed for N cycles starting at cnt=i+1, giving the diagonal skew.
    logic [N-1:0]       rd_en;
    logic [N*IDX_W-1:0] rd_elem;

    always_comb begin
        rd_en   = '0;
        rd_elem = '0;
        for (int i = 0; i < N; i++) begin
            if (running && (int'(cnt_q) > i) && (int'(cnt_q) < i + N + 1)) begin
                rd_en[i]                   = 1'b1;
                rd_elem[i*IDX_W +: IDX_W]  = IDX_W'(int'(cnt_q) - i - 1);
            end
        end
    end

    assign bus.busy               = running;
    assign bus.done               = done_q;
    assign bus.array_write_enable = running;
    assign bus.array_output_row   = out_row_q;
    assign bus.array_output_col   = out_col_q;
    assign bus.result_valid       = rv_q;

    assign bus.mema_data_in       = ld_data_q;
    assign bus.mema_write_enable  = we_a_q;
    assign bus.mema_write_line    = ld_line_q;
    assign bus.mema_write_elem    = ld_elem_q;
    assign bus.mema_read_enable   = rd_en;
    assign bus.mema_read_elem     = rd_elem;

    assign bus.memb_data_in       = ld_data_q;
    assign bus.memb_write_enable  = we_b_q;
    assign bus.memb_write_line    = ld_line_q;
    assign bus.memb_write_elem    = ld_elem_q;
    assign bus.memb_read_enable   = rd_en;
    assign bus.memb_read_elem     = rd_elem;
endmodule

// File: tb/tb_sa_control.sv
// Directed bench for sa_control: an N=4 instance for the command table and run
// corner cases, plus an N=8 instance for the longer skew.
module tb_sa_control;
  localparam int DW = 8;

  localparam logic [1:0] OP_START = 2'b00;
  localparam logic [1:0] OP_STOP  = 2'b01;
  localparam logic [1:0] OP_LOAD  = 2'b10;
  localparam logic [1:0] OP_STORE = 2'b11;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  sa_control_if #(.DATA_WIDTH(DW), .N(4)) bus4 ();
  sa_control_if #(.DATA_WIDTH(DW), .N(8)) bus8 ();

`ifdef SA_CTRL_ERR_EN
  logic err4;
  logic err8;
`endif

  sa_control #(.DATA_WIDTH(DW), .N(4)) u_dut4 (
    .clk (clk),
    .rst (rst),
`ifdef SA_CTRL_ERR_EN
    .err (err4),
`endif
    .bus (bus4.slave)
  );

  sa_control #(.DATA_WIDTH(DW), .N(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
`ifdef SA_CTRL_ERR_EN
    .err (err8),
`endif
    .bus (bus8.slave)
  );

  typedef struct {
    logic       valid;
    logic [1:0] op;
    logic       sel;
    logic [1:0] row;
    logic [1:0] col;
    logic [7:0] data;
    logic       e_busy;
    logic       e_we_a;
    logic       e_we_b;
    logic [7:0] e_din;
    logic [1:0] e_line;
    logic [1:0] e_elem;
    logic       e_rv;
    logic [1:0] e_orow;
    logic [1:0] e_ocol;
  } vec_t;

  vec_t       vecs[8];
  logic [3:0] exp_re4[10];
  logic [7:0] exp_el4[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [14:0] mk4(input logic [1:0] op, input logic sel,
                                      input logic [1:0] row, input logic [1:0] col,
                                      input logic [7:0] data);
    return {op, sel, row, col, data};
  endfunction

  function automatic logic [16:0] mk8(input logic [1:0] op, input logic sel,
                                      input logic [2:0] row, input logic [2:0] col,
                                      input logic [7:0] data);
    return {op, sel, row, col, data};
  endfunction

  task automatic step4();
    @(posedge clk);
    #1;
  endtask

  task automatic issue4(input logic [14:0] ins);
    bus4.instruction = ins;
    bus4.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus4.instr_valid = 1'b0;
  endtask

  task automatic run_full4(input string tag);
    issue4(mk4(OP_START, 1'b0, 2'd0, 2'd0, 8'h00));
    for (int k = 0; k < 10; k++) begin
      check({tag, "_busy"}, 32'(bus4.busy), 32'd1);
      check({tag, "_awe"}, 32'(bus4.array_write_enable), 32'd1);
      check({tag, "_re_a"}, 32'(bus4.mema_read_enable), 32'(exp_re4[k]));
      check({tag, "_re_b"}, 32'(bus4.memb_read_enable), 32'(exp_re4[k]));
      check({tag, "_elem_a"}, 32'(bus4.mema_read_elem), 32'(exp_el4[k]));
      check({tag, "_elem_b"}, 32'(bus4.memb_read_elem), 32'(exp_el4[k]));
      check({tag, "_done_early"}, 32'(bus4.done), 32'd0);
      step4();
    end
    check({tag, "_end_busy"}, 32'(bus4.busy), 32'd0);
    check({tag, "_end_awe"}, 32'(bus4.array_write_enable), 32'd0);
    check({tag, "_end_re"}, 32'(bus4.mema_read_enable), 32'd0);
    check({tag, "_done"}, 32'(bus4.done), 32'd1);
    step4();
    check({tag, "_done_once"}, 32'(bus4.done), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [2:0] e_el;
    logic       e_en;

    //            v     op        sel  row   col   data   busy we_a we_b din    line  elem  rv   orow  ocol
    vecs[0] = '{1'b1, OP_LOAD,  1'b0, 2'd2, 2'd1, 8'hAB, 1'b0, 1'b1, 1'b0, 8'hAB, 2'd2, 2'd1, 1'b0, 2'd0, 2'd0};
    vecs[1] = '{1'b0, OP_STORE, 1'b0, 2'd3, 2'd3, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 1'b0, 2'd0, 2'd0};
    vecs[2] = '{1'b1, OP_LOAD,  1'b1, 2'd1, 2'd3, 8'h3C, 1'b0, 1'b0, 1'b1, 8'h3C, 2'd1, 2'd3, 1'b0, 2'd0, 2'd0};
    vecs[3] = '{1'b1, OP_STORE, 1'b0, 2'd2, 2'd1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 1'b1, 2'd2, 2'd1};
    vecs[4] = '{1'b1, OP_STOP,  1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 1'b0, 2'd2, 2'd1};
    vecs[5] = '{1'b0, OP_START, 1'b0, 2'd0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 1'b0, 2'd2, 2'd1};
    vecs[6] = '{1'b1, OP_STORE, 1'b1, 2'd3, 2'd0, 8'hFF, 1'b0, 1'b0, 1'b0, 8'h00, 2'd0, 2'd0, 1'b1, 2'd3, 2'd0};
    vecs[7] = '{1'b1, OP_LOAD,  1'b0, 2'd3, 2'd3, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 2'd3, 2'd3, 1'b0, 2'd3, 2'd0};

    // N=4 run by cnt 0..9: lane i enabled for cnt i+1..i+4, elem = cnt-i-1
    exp_re4 = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111,
                4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b0000};
    exp_el4 = '{8'h00, 8'h00, 8'h01, 8'h06, 8'h1B,
                8'h6C, 8'hB0, 8'hC0, 8'h00, 8'h00};

    rst = 1'b1;
    bus4.instr_valid = 1'b0;
    bus4.instruction = '0;
    bus8.instr_valid = 1'b0;
    bus8.instruction = '0;

    #2;
    check("rst_busy", 32'(bus4.busy), 32'd0);
    check("rst_done", 32'(bus4.done), 32'd0);
    check("rst_awe", 32'(bus4.array_write_enable), 32'd0);
    check("rst_rv", 32'(bus4.result_valid), 32'd0);
    check("rst_we_a", 32'(bus4.mema_write_enable), 32'd0);
    check("rst_we_b", 32'(bus4.memb_write_enable), 32'd0);
    check("rst_re", 32'(bus4.mema_read_enable), 32'd0);
    check("rst_din", 32'(bus4.mema_data_in), 32'd0);
    check("rst_orow", 32'(bus4.array_output_row), 32'd0);
    check("rst_busy8", 32'(bus8.busy), 32'd0);

    @(posedge clk);
    #1;
    rst = 1'b0;

    // Command table: first record is accepted on the first edge after reset release
    for (int i = 0; i < 8; i++) begin
      bus4.instruction = mk4(vecs[i].op, vecs[i].sel, vecs[i].row, vecs[i].col, vecs[i].data);
      bus4.instr_valid = vecs[i].valid;
      @(posedge clk);
      #1;
      bus4.instr_valid = 1'b0;
      check($sformatf("vec%0d_busy", i), 32'(bus4.busy), 32'(vecs[i].e_busy));
      check($sformatf("vec%0d_we_a", i), 32'(bus4.mema_write_enable), 32'(vecs[i].e_we_a));
      check($sformatf("vec%0d_we_b", i), 32'(bus4.memb_write_enable), 32'(vecs[i].e_we_b));
      check($sformatf("vec%0d_rv", i), 32'(bus4.result_valid), 32'(vecs[i].e_rv));
      check($sformatf("vec%0d_orow", i), 32'(bus4.array_output_row), 32'(vecs[i].e_orow));
      check($sformatf("vec%0d_ocol", i), 32'(bus4.array_output_col), 32'(vecs[i].e_ocol));
      if (vecs[i].e_we_a) begin
        check($sformatf("vec%0d_din_a", i), 32'(bus4.mema_data_in), 32'(vecs[i].e_din));
        check($sformatf("vec%0d_line_a", i), 32'(bus4.mema_write_line), 32'(vecs[i].e_line));
        check($sformatf("vec%0d_elem_a", i), 32'(bus4.mema_write_elem), 32'(vecs[i].e_elem));
      end
      if (vecs[i].e_we_b) begin
        check($sformatf("vec%0d_din_b", i), 32'(bus4.memb_data_in), 32'(vecs[i].e_din));
        check($sformatf("vec%0d_line_b", i), 32'(bus4.memb_write_line), 32'(vecs[i].e_line));
        check($sformatf("vec%0d_elem_b", i), 32'(bus4.memb_write_elem), 32'(vecs[i].e_elem));
      end
    end
    step4();
    check("load_we_a_drop", 32'(bus4.mema_write_enable), 32'd0);
`ifdef SA_CTRL_ERR_EN
    check("err_idle", 32'(err4), 32'd0);
`endif

    run_full4("run1");

    // STOP at cnt=3, then a fresh full run
    issue4(mk4(OP_START, 1'b0, 2'd0, 2'd0, 8'h00));
    step4();
    step4();
    step4();
    check("stop_pre_busy", 32'(bus4.busy), 32'd1);
    check("stop_pre_re", 32'(bus4.mema_read_enable), 32'b0111);
    issue4(mk4(OP_STOP, 1'b0, 2'd0, 2'd0, 8'h00));
    check("stop_busy", 32'(bus4.busy), 32'd0);
    check("stop_awe", 32'(bus4.array_write_enable), 32'd0);
    check("stop_re", 32'(bus4.mema_read_enable), 32'd0);
    for (int k = 0; k < 3; k++) begin
      check("stop_no_done", 32'(bus4.done), 32'd0);
      step4();
    end
    run_full4("run2");

    // START and STORE while busy are ignored
    issue4(mk4(OP_START, 1'b0, 2'd0, 2'd0, 8'h00));
    step4();
    step4();
    issue4(mk4(OP_START, 1'b0, 2'd0, 2'd0, 8'h00));
    check("rstart_busy", 32'(bus4.busy), 32'd1);
    check("rstart_re", 32'(bus4.mema_read_enable), 32'(exp_re4[3]));
    issue4(mk4(OP_STORE, 1'b0, 2'd1, 2'd3, 8'h00));
    check("bstore_rv", 32'(bus4.result_valid), 32'd0);
    check("bstore_orow", 32'(bus4.array_output_row), 32'd3);
    check("bstore_re", 32'(bus4.mema_read_enable), 32'(exp_re4[4]));
`ifdef SA_CTRL_ERR_EN
    check("err_set", 32'(err4), 32'd1);
`endif
    n = 0;
    while (bus4.busy === 1'b1 && n < 40) begin
      n++;
      step4();
    end
    check("busy_tail_cycles", 32'(n), 32'd6);
    check("busy_tail_done", 32'(bus4.done), 32'd1);
    issue4(mk4(OP_STORE, 1'b0, 2'd1, 2'd3, 8'h00));
    check("istore_rv", 32'(bus4.result_valid), 32'd1);
    check("istore_orow", 32'(bus4.array_output_row), 32'd1);
    check("istore_ocol", 32'(bus4.array_output_col), 32'd3);
    step4();
    check("istore_rv_drop", 32'(bus4.result_valid), 32'd0);
    check("istore_orow_hold", 32'(bus4.array_output_row), 32'd1);
    check("istore_ocol_hold", 32'(bus4.array_output_col), 32'd3);
`ifdef SA_CTRL_ERR_EN
    check("err_sticky", 32'(err4), 32'd1);
    issue4(mk4(OP_STOP, 1'b0, 2'd0, 2'd0, 8'h00));
    check("err_clear", 32'(err4), 32'd0);
`endif

    // Reset mid-run at cnt=5
    issue4(mk4(OP_START, 1'b0, 2'd0, 2'd0, 8'h00));
    for (int k = 0; k < 5; k++) step4();
    check("mrst_pre_re", 32'(bus4.mema_read_enable), 32'b1110);
    #2;
    rst = 1'b1;
    #1;
    check("mrst_busy", 32'(bus4.busy), 32'd0);
    check("mrst_awe", 32'(bus4.array_write_enable), 32'd0);
    check("mrst_re", 32'(bus4.mema_read_enable), 32'd0);
    check("mrst_elem", 32'(bus4.mema_read_elem), 32'd0);
    check("mrst_orow", 32'(bus4.array_output_row), 32'd0);
    check("mrst_done", 32'(bus4.done), 32'd0);
    step4();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step4();
      check("mrst_no_done", 32'(bus4.done), 32'd0);
      check("mrst_idle", 32'(bus4.busy), 32'd0);
    end
    issue4(mk4(OP_LOAD, 1'b1, 2'd3, 2'd0, 8'h5C));
    check("ldb_we_b", 32'(bus4.memb_write_enable), 32'd1);
    check("ldb_we_a", 32'(bus4.mema_write_enable), 32'd0);
    check("ldb_din", 32'(bus4.memb_data_in), 32'h5C);
    check("ldb_line", 32'(bus4.memb_write_line), 32'd3);
    check("ldb_elem", 32'(bus4.memb_write_elem), 32'd0);
    step4();
    check("ldb_we_b_drop", 32'(bus4.memb_write_enable), 32'd0);

    // N=8 run: 18 busy cycles, lane 7 fed at cnt 8..15
    bus8.instruction = mk8(OP_START, 1'b0, 3'd0, 3'd0, 8'h00);
    bus8.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus8.instr_valid = 1'b0;
    for (int k = 0; k < 18; k++) begin
      e_en = (k >= 8) && (k <= 15);
      e_el = e_en ? 3'(k - 8) : 3'd0;
      check("n8_busy", 32'(bus8.busy), 32'd1);
      check("n8_awe", 32'(bus8.array_write_enable), 32'd1);
      check("n8_re7", 32'(bus8.mema_read_enable[7]), 32'(e_en));
      check("n8_elem7", 32'(bus8.mema_read_elem[23:21]), 32'(e_el));
      check("n8_done_early", 32'(bus8.done), 32'd0);
      @(posedge clk);
      #1;
    end
    check("n8_end_busy", 32'(bus8.busy), 32'd0);
    check("n8_end_re", 32'(bus8.memb_read_enable), 32'd0);
    check("n8_done", 32'(bus8.done), 32'd1);
    @(posedge clk);
    #1;
    check("n8_done_once", 32'(bus8.done), 32'd0);
`ifdef SA_CTRL_ERR_EN
    check("n8_err", 32'(err8), 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
